// File: rtl/histogram_esitleme_birimi_pkg.sv
// Shared types for the histogram equalisation engine:
// top-level FSM states, MAP sub-phases and logic levels.
package histogram_esitleme_birimi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    SCAN,
    MAP,
    DONE
  } durum_t;

  typedef enum logic [1:0] {
    M_OKU,
    M_KARAR,
    M_BOL
  } map_faz_t;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage

// File: rtl/ardisik_bolucu.sv
// Restoring divider, one quotient bit per cycle.
// basla_i loads operands; bitti_o pulses with bolum_o valid.
module ardisik_bolucu #(
  parameter int W = 25
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         basla_i,
  input  logic [W-1:0] bolunen_i,
  input  logic [W-1:0] bolen_i,
  output logic [W-1:0] bolum_o,
  output logic         bitti_o
);

  localparam int AW = $clog2(W + 1);
  localparam logic [AW-1:0] SON_ADIM = AW'(W - 1);

  logic [W-1:0]  kalan_q, kalan_d;
  logic [W-1:0]  bolum_q, bolum_d;
  logic [W-1:0]  bolen_q, bolen_d;
  logic [AW-1:0] adim_q, adim_d;
  logic          calisiyor_q, calisiyor_d;
  logic          bitti_q, bitti_d;
  logic [W:0]    deneme;
  logic          bolum_bit;

  always_comb begin
    kalan_d     = kalan_q;
    bolum_d     = bolum_q;
    bolen_d     = bolen_q;
    adim_d      = adim_q;
    calisiyor_d = calisiyor_q;
    bitti_d     = 1'b0;
    deneme      = '0;
    bolum_bit   = 1'b0;
    if (basla_i) begin
      kalan_d     = '0;
      bolum_d     = bolunen_i;
      bolen_d     = bolen_i;
      adim_d      = '0;
      calisiyor_d = 1'b1;
    end else if (calisiyor_q) begin
      // dividend bits shift out of bolum_q into the remainder
      deneme    = {kalan_q, bolum_q[W-1]};
      bolum_bit = (deneme >= {1'b0, bolen_q});
      if (bolum_bit) begin
        deneme = deneme - {1'b0, bolen_q};
      end
      kalan_d = deneme[W-1:0];
      bolum_d = {bolum_q[W-2:0], bolum_bit};
      adim_d  = adim_q + 1'b1;
      if (adim_q == SON_ADIM) begin
        calisiyor_d = 1'b0;
        bitti_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kalan_q     <= '0;
      bolum_q     <= '0;
      bolen_q     <= '0;
      adim_q      <= '0;
      calisiyor_q <= 1'b0;
      bitti_q     <= 1'b0;
    end else begin
      kalan_q     <= kalan_d;
      bolum_q     <= bolum_d;
      bolen_q     <= bolen_d;
      adim_q      <= adim_d;
      calisiyor_q <= calisiyor_d;
      bitti_q     <= bitti_d;
    end
  end

  assign bolum_o = bolum_q;
  assign bitti_o = bitti_q;

endmodule

// File: rtl/histogram_esitleme_birimi.sv
// Histogram equalisation engine: count, in-place CDF, LUT build.
// Define HIST_DOYUM_EN for saturating bin/total counters.
module histogram_esitleme_birimi
  import histogram_esitleme_birimi_pkg::*;
#(
  parameter int PIXEL_BIT = 8,
  parameter int SAYAC_BIT = 17
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 basla_i,
  input  logic                 pixel_gecerli_i,
  input  logic [PIXEL_BIT-1:0] pixel_i,
  input  logic                 pixel_son_i,
  output logic                 pixel_hazir_o,
  input  logic [PIXEL_BIT-1:0] lut_addr_i,
  output logic [PIXEL_BIT-1:0] lut_data_o,
  output logic [SAYAC_BIT-1:0] cdf_min_o,
  output logic [SAYAC_BIT-1:0] toplam_o,
  output logic                 mesgul_o,
  output logic                 hazir_o,
  output logic                 tasma_o
);

  localparam int P  = PIXEL_BIT;
  localparam int S  = SAYAC_BIT;
  localparam int NB = 2 ** P;
  localparam int NW = S + P;
  localparam logic [S-1:0] S_MAX = '1;
  localparam logic [P-1:0] P_MAX = '1;
  localparam logic [P:0]   SCAN_SON = {1'b1, {P{1'b0}}};

  durum_t   durum_q, durum_d;
  map_faz_t faz_q, faz_d;

  logic [P:0]   sayac_q, sayac_d;
  logic         s1_gecerli_q, s1_gecerli_d;
  logic [P-1:0] s1_addr_q, s1_addr_d;
  logic         fw_gecerli_q, fw_gecerli_d;
  logic [P-1:0] fw_addr_q, fw_addr_d;
  logic [S-1:0] fw_veri_q, fw_veri_d;
  logic [S-1:0] bin_rd_q, bin_rd_d;
  logic [S-1:0] toplam_q, toplam_d;
  logic [S-1:0] kumul_q, kumul_d;
  logic [S-1:0] cdf_min_q, cdf_min_d;
  logic         min_var_q, min_var_d;
  logic         tasma_q, tasma_d;
  logic [P-1:0] lut_data_q, lut_data_d;

  logic [S-1:0] bin_ram [NB];
  logic [P-1:0] lut_ram [NB];

  logic         bin_yaz_en;
  logic [P-1:0] bin_yaz_addr, bin_oku_addr;
  logic [S-1:0] bin_yaz_veri;
  logic         lut_yaz_en;
  logic [P-1:0] lut_yaz_veri;

  logic          kabul, basla_ok, map_bitti, ilerle;
  logic [S-1:0]  eski, yeni, kumul_yeni, den;
  logic          bol_basla, bol_bitti;
  logic [NW-1:0] bolunen, bolen, bolum;

  assign kabul    = pixel_gecerli_i & pixel_hazir_o;
  assign basla_ok = basla_i & (durum_q == IDLE || durum_q == DONE);
  assign den      = toplam_q - cdf_min_q;
  assign bolen    = {{P{1'b0}}, den};
  assign bolunen  = {{P{1'b0}}, bin_rd_q - cdf_min_q}
                  * {{S{1'b0}}, P_MAX}
                  + {{P{1'b0}}, den >> 1};

  ardisik_bolucu #(
    .W(NW)
  ) u_bolucu (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .basla_i   (bol_basla),
    .bolunen_i (bolunen),
    .bolen_i   (bolen),
    .bolum_o   (bolum),
    .bitti_o   (bol_bitti)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q <= IDLE;
    end else begin
      durum_q <= durum_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    unique case (durum_q)
      IDLE:  if (basla_i) durum_d = CLEAR;
      CLEAR: if (sayac_q[P-1:0] == P_MAX) durum_d = ACCUM;
      ACCUM: if (kabul && pixel_son_i) durum_d = DRAIN;
      DRAIN: durum_d = SCAN;
      SCAN:  if (sayac_q == SCAN_SON) durum_d = MAP;
      MAP:   if (map_bitti) durum_d = DONE;
      DONE:  if (basla_i) durum_d = CLEAR;
      default: durum_d = IDLE;
    endcase
  end

  always_comb begin
    pixel_hazir_o = (durum_q == ACCUM) ? HIGH : LOW;
    hazir_o       = (durum_q == DONE) ? HIGH : LOW;
    mesgul_o      = (durum_q != IDLE && durum_q != DONE) ? HIGH : LOW;
  end

  always_comb begin
    sayac_d      = sayac_q;
    faz_d        = faz_q;
    s1_gecerli_d = kabul;
    s1_addr_d    = pixel_i;
    fw_gecerli_d = LOW;
    fw_addr_d    = fw_addr_q;
    fw_veri_d    = fw_veri_q;
    toplam_d     = toplam_q;
    kumul_d      = kumul_q;
    cdf_min_d    = cdf_min_q;
    min_var_d    = min_var_q;
    tasma_d      = tasma_q;
    bin_yaz_en   = LOW;
    bin_yaz_addr = '0;
    bin_yaz_veri = '0;
    bin_oku_addr = pixel_i;
    lut_yaz_en   = LOW;
    lut_yaz_veri = '0;
    bol_basla    = LOW;
    map_bitti    = LOW;
    ilerle       = LOW;
    eski         = '0;
    yeni         = '0;
    kumul_yeni   = '0;

    if (basla_ok) begin
      sayac_d   = '0;
      faz_d     = M_OKU;
      toplam_d  = '0;
      kumul_d   = '0;
      cdf_min_d = '0;
      min_var_d = LOW;
      tasma_d   = LOW;
    end

    if (kabul) begin
      if (toplam_q == S_MAX) begin
        tasma_d = HIGH;
`ifdef HIST_DOYUM_EN
        toplam_d = S_MAX;
`else
        toplam_d = '0;
`endif
      end else begin
        toplam_d = toplam_q + 1'b1;
      end
    end

    // RMW second stage; RAM read is one write behind, so forward it
    if (s1_gecerli_q) begin
      eski = (fw_gecerli_q && fw_addr_q == s1_addr_q)
           ? fw_veri_q : bin_rd_q;
      if (eski == S_MAX) begin
        tasma_d = HIGH;
`ifdef HIST_DOYUM_EN
        yeni = S_MAX;
`else
        yeni = '0;
`endif
      end else begin
        yeni = eski + 1'b1;
      end
      bin_yaz_en   = HIGH;
      bin_yaz_addr = s1_addr_q;
      bin_yaz_veri = yeni;
      fw_gecerli_d = HIGH;
      fw_addr_d    = s1_addr_q;
      fw_veri_d    = yeni;
    end

    unique case (durum_q)
      CLEAR: begin
        bin_yaz_en   = HIGH;
        bin_yaz_addr = sayac_q[P-1:0];
        sayac_d      = (sayac_q[P-1:0] == P_MAX)
                     ? '0 : sayac_q + 1'b1;
      end
      SCAN: begin
        bin_oku_addr = sayac_q[P-1:0];
        sayac_d      = (sayac_q == SCAN_SON)
                     ? '0 : sayac_q + 1'b1;
        if (sayac_q != '0) begin
          kumul_yeni   = kumul_q + bin_rd_q;
          kumul_d      = kumul_yeni;
          bin_yaz_en   = HIGH;
          bin_yaz_addr = sayac_q[P-1:0] - 1'b1;
          bin_yaz_veri = kumul_yeni;
          if (!min_var_q && bin_rd_q != '0) begin
            cdf_min_d = kumul_yeni;
            min_var_d = HIGH;
          end
        end
      end
      MAP: begin
        bin_oku_addr = sayac_q[P-1:0];
        unique case (faz_q)
          M_OKU: faz_d = M_KARAR;
          M_KARAR: begin
            if (bin_rd_q == '0) begin
              ilerle = HIGH;
            end else if (den == '0) begin
              lut_yaz_veri = sayac_q[P-1:0];
              ilerle       = HIGH;
            end else begin
              bol_basla = HIGH;
              faz_d     = M_BOL;
            end
          end
          M_BOL: begin
            if (bol_bitti) begin
              lut_yaz_veri = (bolum > {{S{1'b0}}, P_MAX})
                           ? P_MAX : bolum[P-1:0];
              ilerle       = HIGH;
            end
          end
          default: faz_d = M_OKU;
        endcase
        if (ilerle) begin
          lut_yaz_en = HIGH;
          faz_d      = M_OKU;
          if (sayac_q[P-1:0] == P_MAX) begin
            map_bitti = HIGH;
            sayac_d   = '0;
          end else begin
            sayac_d = sayac_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bin_rd_d   = bin_ram[bin_oku_addr];
  assign lut_data_d = lut_ram[lut_addr_i];

  always_ff @(posedge clk_i) begin
    if (bin_yaz_en) begin
      bin_ram[bin_yaz_addr] <= bin_yaz_veri;
    end
    if (lut_yaz_en) begin
      lut_ram[sayac_q[P-1:0]] <= lut_yaz_veri;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      faz_q        <= M_OKU;
      sayac_q      <= '0;
      s1_gecerli_q <= LOW;
      s1_addr_q    <= '0;
      fw_gecerli_q <= LOW;
      fw_addr_q    <= '0;
      fw_veri_q    <= '0;
      bin_rd_q     <= '0;
      toplam_q     <= '0;
      kumul_q      <= '0;
      cdf_min_q    <= '0;
      min_var_q    <= LOW;
      tasma_q      <= LOW;
      lut_data_q   <= '0;
    end else begin
      faz_q        <= faz_d;
      sayac_q      <= sayac_d;
      s1_gecerli_q <= s1_gecerli_d;
      s1_addr_q    <= s1_addr_d;
      fw_gecerli_q <= fw_gecerli_d;
      fw_addr_q    <= fw_addr_d;
      fw_veri_q    <= fw_veri_d;
      bin_rd_q     <= bin_rd_d;
      toplam_q     <= toplam_d;
      kumul_q      <= kumul_d;
      cdf_min_q    <= cdf_min_d;
      min_var_q    <= min_var_d;
      tasma_q      <= tasma_d;
      lut_data_q   <= lut_data_d;
    end
  end

  assign lut_data_o = lut_data_q;
  assign cdf_min_o  = cdf_min_q;
  assign toplam_o   = toplam_q;
  assign tasma_o    = tasma_q;

endmodule

// File: tb/tb_histogram_esitleme_birimi.sv
// Directed bench: 17-bit counter instance for frames,
// 4-bit counter instance for overflow behaviour.
module tb_histogram_esitleme_birimi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        basla = 0, gecerli = 0, son = 0;
  logic [7:0]  pixel = 0, lut_addr = 0;
  logic        pixel_hazir, mesgul, hazir, tasma;
  logic [7:0]  lut_data;
  logic [16:0] cdf_min, toplam;

  logic        b_basla = 0, b_gecerli = 0, b_son = 0;
  logic [7:0]  b_pixel = 0, b_lut_addr = 0;
  logic        b_pixel_hazir, b_mesgul, b_hazir, b_tasma;
  logic [7:0]  b_lut_data;
  logic [3:0]  b_cdf_min, b_toplam;

  int kontrol_sayisi = 0;
  int hata_sayisi = 0;

  histogram_esitleme_birimi #(
    .PIXEL_BIT(8), .SAYAC_BIT(17)
  ) dut (
    .clk_i(clk), .rst_i(rst), .basla_i(basla),
    .pixel_gecerli_i(gecerli), .pixel_i(pixel),
    .pixel_son_i(son), .pixel_hazir_o(pixel_hazir),
    .lut_addr_i(lut_addr), .lut_data_o(lut_data),
    .cdf_min_o(cdf_min), .toplam_o(toplam),
    .mesgul_o(mesgul), .hazir_o(hazir), .tasma_o(tasma)
  );

  histogram_esitleme_birimi #(
    .PIXEL_BIT(8), .SAYAC_BIT(4)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .basla_i(b_basla),
    .pixel_gecerli_i(b_gecerli), .pixel_i(b_pixel),
    .pixel_son_i(b_son), .pixel_hazir_o(b_pixel_hazir),
    .lut_addr_i(b_lut_addr), .lut_data_o(b_lut_data),
    .cdf_min_o(b_cdf_min), .toplam_o(b_toplam),
    .mesgul_o(b_mesgul), .hazir_o(b_hazir), .tasma_o(b_tasma)
  );

  task automatic kontrol(input string etiket,
                         input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%0d beklenen=%0d",
               etiket, gozlenen, beklenen);
    end
  endtask

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  task automatic basla_ver();
    basla = 1;
    adim();
    basla = 0;
  endtask

  task automatic kabul_bekle();
    for (int i = 0; i < 1000 && !pixel_hazir; i++) adim();
    kontrol("kabul_zaman", pixel_hazir, 1);
  endtask

  task automatic bitis_bekle();
    for (int i = 0; i < 20000 && !hazir; i++) adim();
    kontrol("bitis_zaman", hazir, 1);
  endtask

  task automatic piksel(input logic [7:0] p, input logic s);
    gecerli = 1;
    pixel = p;
    son = s;
    adim();
    gecerli = 0;
    son = 0;
  endtask

  task automatic lut_kontrol(input string etiket,
                             input logic [7:0] a,
                             input logic [7:0] beklenen);
    lut_addr = a;
    adim();
    kontrol(etiket, {24'd0, lut_data}, {24'd0, beklenen});
  endtask

  task automatic cerceve_t2();
    piksel(8'd0, 0);
    piksel(8'd85, 0);
    piksel(8'd170, 0);
    piksel(8'd255, 1);
  endtask

  initial begin
    logic [3:0] b_beklenen;
`ifdef HIST_DOYUM_EN
    b_beklenen = 4'd15;
`else
    b_beklenen = 4'd4;
`endif

    // reset state
    rst = 1;
    repeat (3) adim();
    kontrol("rst_mesgul", mesgul, 0);
    kontrol("rst_hazir", hazir, 0);
    kontrol("rst_pix_hazir", pixel_hazir, 0);
    kontrol("rst_tasma", tasma, 0);
    kontrol("rst_cdf_min", cdf_min, 0);
    kontrol("rst_toplam", toplam, 0);
    kontrol("rst_lut", lut_data, 0);
    rst = 0;
    adim();
    basla_ver();
    kontrol("basla_mesgul", mesgul, 1);

    // evenly spread frame
    kabul_bekle();
    cerceve_t2();
    bitis_bekle();
    kontrol("t2_cdf_min", cdf_min, 1);
    kontrol("t2_toplam", toplam, 4);
    kontrol("t2_tasma", tasma, 0);
    kontrol("t2_mesgul", mesgul, 0);
    lut_kontrol("t2_lut0", 8'd0, 8'd0);
    lut_kontrol("t2_lut85", 8'd85, 8'd85);
    lut_kontrol("t2_lut170", 8'd170, 8'd170);
    lut_kontrol("t2_lut255", 8'd255, 8'd255);
    lut_kontrol("t2_lut100", 8'd100, 8'd85);

    // start wins over a beat in DONE; then same-bin burst
    gecerli = 1;
    pixel = 8'd7;
    basla_ver();
    gecerli = 0;
    kontrol("t3_pix_hazir", pixel_hazir, 0);
    kabul_bekle();
    for (int i = 0; i < 16; i++) piksel(8'd7, i == 15);
    bitis_bekle();
    kontrol("t3_toplam", toplam, 16);
    kontrol("t3_bin7", cdf_min, 16);
    lut_kontrol("t3_lut7", 8'd7, 8'd7);
    lut_kontrol("t3_lut3", 8'd3, 8'd0);
    lut_kontrol("t3_lut200", 8'd200, 8'd200);

    // skewed frame
    basla_ver();
    kabul_bekle();
    piksel(8'd10, 0);
    piksel(8'd10, 0);
    piksel(8'd10, 0);
    piksel(8'd200, 1);
    bitis_bekle();
    kontrol("t4_cdf_min", cdf_min, 3);
    kontrol("t4_toplam", toplam, 4);
    lut_kontrol("t4_lut10", 8'd10, 8'd0);
    lut_kontrol("t4_lut50", 8'd50, 8'd0);
    lut_kontrol("t4_lut200", 8'd200, 8'd255);
    lut_kontrol("t4_lut5", 8'd5, 8'd0);

    // abort mid-frame, rerun, start pulse during SCAN
    basla_ver();
    kabul_bekle();
    piksel(8'd5, 0);
    piksel(8'd6, 0);
    rst = 1;
    adim();
    rst = 0;
    kontrol("t6_iptal_mesgul", mesgul, 0);
    kontrol("t6_iptal_toplam", toplam, 0);
    basla_ver();
    kabul_bekle();
    cerceve_t2();
    repeat (4) adim();
    basla_ver();
    bitis_bekle();
    kontrol("t6_cdf_min", cdf_min, 1);
    kontrol("t6_toplam", toplam, 4);
    lut_kontrol("t6_lut85", 8'd85, 8'd85);
    lut_kontrol("t6_lut170", 8'd170, 8'd170);
    lut_kontrol("t6_lut100", 8'd100, 8'd85);

    // narrow counters: overflow on bin and total
    b_basla = 1;
    adim();
    b_basla = 0;
    for (int i = 0; i < 1000 && !b_pixel_hazir; i++) adim();
    kontrol("b_kabul_zaman", b_pixel_hazir, 1);
    for (int i = 0; i < 20; i++) begin
      b_gecerli = 1;
      b_pixel = 8'd3;
      b_son = (i == 19);
      adim();
    end
    b_gecerli = 0;
    b_son = 0;
    for (int i = 0; i < 20000 && !b_hazir; i++) adim();
    kontrol("b_bitis_zaman", b_hazir, 1);
    kontrol("b_mesgul", b_mesgul, 0);
    kontrol("b_bin3", {28'd0, b_cdf_min}, {28'd0, b_beklenen});
    kontrol("b_toplam", {28'd0, b_toplam}, {28'd0, b_beklenen});
    kontrol("b_tasma", b_tasma, 1);
    b_lut_addr = 8'd3;
    adim();
    kontrol("b_lut3", {24'd0, b_lut_data}, 32'd3);
    b_basla = 1;
    adim();
    b_basla = 0;
    kontrol("b_tasma_temiz", b_tasma, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
